// File: rtl/bip_pkg.sv
// Shared types and word-count helpers for the BIP-I run/report sequencer.
// Word counts grow by one when BIP_REPORT_CHECKSUM_EN is defined.
package bip_pkg;

    localparam int DEFAULT_HALT_OPCODE        = 0;
    localparam int DEFAULT_OUTPUT_WORD_LENGTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SEND,
        ST_WAIT_TX,
        ST_DONE
    } state_t;

    function automatic int words_for(input int bits, input int word_len);
        return (bits + word_len - 1) / word_len;
    endfunction

    function automatic int cc_words(input int cc_len, input int word_len);
        return words_for(cc_len, word_len);
    endfunction

    function automatic int acc_words(input int acc_len, input int word_len);
        return words_for(acc_len, word_len);
    endfunction

    function automatic int n_words(input int cc_len, input int acc_len, input int word_len);
`ifdef BIP_REPORT_CHECKSUM_EN
        return cc_words(cc_len, word_len) + acc_words(acc_len, word_len) + 1;
`else
        return cc_words(cc_len, word_len) + acc_words(acc_len, word_len);
`endif
    endfunction

endpackage

// File: rtl/bip_word_serializer.sv
// Frozen CC/ACC snapshot plus word counter; presents word[counter] to the UART.
// With BIP_REPORT_CHECKSUM_EN the final word is the XOR of all data words.
module bip_word_serializer
    import bip_pkg::*;
#(
    parameter int CC_LENGTH   = 11,
    parameter int ACC_LENGTH  = 16,
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   capture,
    input  logic                   advance,
    input  logic [CC_LENGTH-1:0]   cc,
    input  logic [ACC_LENGTH-1:0]  acc,
    output logic [WORD_LENGTH-1:0] word,
    output logic                   last
);

    localparam int CC_WORDS   = cc_words(CC_LENGTH, WORD_LENGTH);
    localparam int ACC_WORDS  = acc_words(ACC_LENGTH, WORD_LENGTH);
    localparam int DATA_WORDS = CC_WORDS + ACC_WORDS;
    localparam int N_WORDS    = n_words(CC_LENGTH, ACC_LENGTH, WORD_LENGTH);
    localparam int CNT_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int SNAP_W     = DATA_WORDS * WORD_LENGTH;

    logic [CC_WORDS*WORD_LENGTH-1:0]  cc_ext;
    logic [ACC_WORDS*WORD_LENGTH-1:0] acc_ext;
    logic [SNAP_W-1:0]                snapshot;
    logic [CNT_W-1:0]                 count;

    always_comb begin
        cc_ext                 = '0;
        cc_ext[CC_LENGTH-1:0]  = cc;
        acc_ext                = '0;
        acc_ext[ACC_LENGTH-1:0] = acc;
    end

    // CC occupies the low words so word 0 is the CC least-significant byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            snapshot <= '0;
            count    <= '0;
        end else if (capture) begin
            snapshot <= {acc_ext, cc_ext};
            count    <= '0;
        end else if (advance) begin
            count    <= count + CNT_W'(1);
        end
    end

`ifdef BIP_REPORT_CHECKSUM_EN
    logic [WORD_LENGTH-1:0] checksum;

    always_comb begin
        checksum = '0;
        for (int k = 0; k < DATA_WORDS; k++) begin
            checksum = checksum ^ snapshot[k*WORD_LENGTH +: WORD_LENGTH];
        end
    end
`endif

    always_comb begin
        word = '0;
        for (int k = 0; k < DATA_WORDS; k++) begin
            if (count == CNT_W'(k)) begin
                word = snapshot[k*WORD_LENGTH +: WORD_LENGTH];
            end
        end
`ifdef BIP_REPORT_CHECKSUM_EN
        if (count == CNT_W'(N_WORDS - 1)) begin
            word = checksum;
        end
`endif
    end

    assign last = (count == CNT_W'(N_WORDS - 1));

endmodule

// File: rtl/bip_report_sequencer.sv
// Run/report controller: runs the BIP-I CPU until HALT, then streams CC and ACC
// to the UART one word per handshake. Optional checksum word: BIP_REPORT_CHECKSUM_EN.
//
// state      | meaning
// IDLE       | waiting for host run command, CPU stopped
// RUN        | CPU enabled, watching for HALT opcode
// SEND       | one-cycle transmit request for the current word
// WAIT_TX    | holding the word until the UART reports done
// DONE       | one-cycle completion pulse
module bip_report_sequencer
    import bip_pkg::*;
#(
    parameter int CANT_BITS_OPCODE   = 5,
    parameter int CC_LENGTH          = 11,
    parameter int ACC_LENGTH         = 16,
    parameter int OUTPUT_WORD_LENGTH = DEFAULT_OUTPUT_WORD_LENGTH,
    parameter int HALT_OPCODE        = DEFAULT_HALT_OPCODE
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_run,
    input  logic [CANT_BITS_OPCODE-1:0]   i_opcode,
    input  logic [CC_LENGTH-1:0]          i_cc,
    input  logic [ACC_LENGTH-1:0]         i_acc,
    input  logic                          i_tx_done,
    output logic                          o_cpu_enable,
    output logic                          o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0] o_data_tx,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam logic [CANT_BITS_OPCODE-1:0] HALT_CODE = CANT_BITS_OPCODE'(HALT_OPCODE);

    state_t state;
    state_t state_next;
    logic   halt_seen;
    logic   capture;
    logic   advance;
    logic   last_word;

    assign halt_seen = (i_opcode == HALT_CODE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (i_run) state_next = ST_RUN;
            ST_RUN:     if (halt_seen) state_next = ST_SEND;
            ST_SEND:    state_next = ST_WAIT_TX;
            ST_WAIT_TX: if (i_tx_done) state_next = last_word ? ST_DONE : ST_SEND;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_cpu_enable = (state == ST_RUN);
        o_tx_start   = (state == ST_SEND);
        o_busy       = (state != ST_IDLE);
        o_done       = (state == ST_DONE);
    end

    assign capture = (state == ST_RUN) && halt_seen;
    assign advance = (state == ST_WAIT_TX) && i_tx_done && !last_word;

    bip_word_serializer #(
        .CC_LENGTH   (CC_LENGTH),
        .ACC_LENGTH  (ACC_LENGTH),
        .WORD_LENGTH (OUTPUT_WORD_LENGTH)
    ) u_serializer (
        .clock   (i_clock),
        .reset   (i_reset),
        .capture (capture),
        .advance (advance),
        .cc      (i_cc),
        .acc     (i_acc),
        .word    (o_data_tx),
        .last    (last_word)
    );

endmodule

// File: tb/tb_bip_report_sequencer.sv
// Directed bench for bip_report_sequencer: default instance plus a CC_LENGTH=8 instance.
module tb_bip_report_sequencer;

`ifdef BIP_REPORT_CHECKSUM_EN
    localparam int N_EXP  = 5;
    localparam int N_EXP8 = 4;
`else
    localparam int N_EXP  = 4;
    localparam int N_EXP8 = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset = 1'b1;
    logic        i_run = 1'b0;
    logic [4:0]  i_opcode = 5'd3;
    logic [10:0] i_cc = '0;
    logic [15:0] i_acc = '0;
    logic        i_tx_done = 1'b0;
    logic        o_cpu_enable, o_tx_start, o_busy, o_done;
    logic [7:0]  o_data_tx;

    logic        run8 = 1'b0;
    logic [4:0]  opcode8 = 5'd3;
    logic [7:0]  cc8 = '0;
    logic [15:0] acc8 = '0;
    logic        tx_done8 = 1'b0;
    logic        cpu_enable8, tx_start8, busy8, done8;
    logic [7:0]  data_tx8;

    bip_report_sequencer dut (
        .i_clock(clk), .i_reset(i_reset), .i_run(i_run), .i_opcode(i_opcode),
        .i_cc(i_cc), .i_acc(i_acc), .i_tx_done(i_tx_done),
        .o_cpu_enable(o_cpu_enable), .o_tx_start(o_tx_start), .o_data_tx(o_data_tx),
        .o_busy(o_busy), .o_done(o_done)
    );

    bip_report_sequencer #(.CC_LENGTH(8)) dut8 (
        .i_clock(clk), .i_reset(i_reset), .i_run(run8), .i_opcode(opcode8),
        .i_cc(cc8), .i_acc(acc8), .i_tx_done(tx_done8),
        .o_cpu_enable(cpu_enable8), .o_tx_start(tx_start8), .o_data_tx(data_tx8),
        .o_busy(busy8), .o_done(done8)
    );

    int checks = 0;
    int fails  = 0;

    logic [7:0] exp_words  [5] = '{8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hF6};
    logic [7:0] exp_words8 [4] = '{8'h5A, 8'h34, 8'h12, 8'h7C};

    logic [7:0] got [8];
    int         n_starts, n_dones, unstable, en_cycles;
    bit         timed_out;
    logic       halt_en, halt_start;
    logic [7:0] done_data;
    logic [11:0] rst_outs;

    // Host run with 10 non-HALT cycles, then HALT with cc=2A5 / acc=BEEF.
    task automatic run_phase(input bit spurious, input bit rerun);
        en_cycles = 0;
        i_cc  = 11'h155;
        i_acc = 16'h1111;
        @(negedge clk);
        i_run    = 1'b1;
        i_opcode = 5'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_run     = rerun && (i == 3);
            i_tx_done = spurious && (i == 2);
            if (o_cpu_enable) en_cycles++;
            if (i == 9) begin
                i_opcode = 5'd0;
                i_cc     = 11'h2A5;
                i_acc    = 16'hBEEF;
            end
        end
        @(negedge clk);
        halt_en    = o_cpu_enable;
        halt_start = o_tx_start;
    endtask

    // UART model: answers each start with i_tx_done after tx_delay cycles.
    task automatic serve(input int tx_delay, input bit corrupt, input bit rerun,
                         input bit spurious_send, input int abort_after);
        int wait_cnt = 0;
        int tail = -1;
        n_starts = 0; n_dones = 0; unstable = 0; timed_out = 1'b1; done_data = '0;
        for (int c = 0; c < 20000; c++) begin
            i_tx_done = 1'b0;
            i_run     = 1'b0;
            if (o_tx_start) begin
                if (n_starts < 8) got[n_starts] = o_data_tx;
                n_starts++;
                wait_cnt  = tx_delay;
                i_tx_done = spurious_send;
            end else if (wait_cnt > 0) begin
                if (n_starts <= 8 && o_data_tx !== got[n_starts-1]) unstable++;
                if (corrupt) begin
                    i_cc  = '1;
                    i_acc = '1;
                end
                if (rerun && wait_cnt == tx_delay - 1) i_run = 1'b1;
                if (abort_after != 0 && n_starts == abort_after && wait_cnt == tx_delay / 2) begin
                    i_reset = 1'b1;
                    @(negedge clk);
                    i_reset  = 1'b0;
                    rst_outs = {o_cpu_enable, o_tx_start, o_busy, o_done, o_data_tx};
                    wait_cnt = 0;
                    tail     = 10;
                end else begin
                    wait_cnt--;
                    if (wait_cnt == 0) i_tx_done = 1'b1;
                end
            end
            if (o_done) begin
                n_dones++;
                done_data = o_data_tx;
                if (tail < 0) tail = 6;
            end
            if (tail == 0) begin
                timed_out = 1'b0;
                break;
            end
            if (tail > 0) tail--;
            @(negedge clk);
        end
        i_tx_done = 1'b0;
        i_run     = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({o_cpu_enable, o_tx_start, o_busy, o_done, o_data_tx} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 000", {o_cpu_enable, o_tx_start, o_busy, o_done, o_data_tx});
        end
        checks++;
        if ({cpu_enable8, tx_start8, busy8, done8, data_tx8} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs8: got %h expected 000", {cpu_enable8, tx_start8, busy8, done8, data_tx8});
        end
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy %b expected 0", o_busy);
        end
    endtask

    task automatic test_basic();
        run_phase(1'b0, 1'b0);
        checks++;
        if (en_cycles != 10) begin
            fails++;
            $display("FAIL basic_run_len: enable cycles %0d expected 10", en_cycles);
        end
        checks++;
        if ({halt_en, halt_start} !== 2'b01) begin
            fails++;
            $display("FAIL basic_halt: enable/start %b expected 01", {halt_en, halt_start});
        end
        serve(20, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (timed_out || n_starts != N_EXP || n_dones != 1) begin
            fails++;
            $display("FAIL basic_counts: timeout %0d starts %0d dones %0d expected 0 %0d 1", timed_out, n_starts, n_dones, N_EXP);
        end
        for (int k = 0; k < N_EXP; k++) begin
            checks++;
            if (got[k] !== exp_words[k]) begin
                fails++;
                $display("FAIL basic_word%0d: got %h expected %h", k, got[k], exp_words[k]);
            end
        end
        checks++;
        if (done_data !== exp_words[N_EXP-1] || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_state: data %h busy %b expected %h 0", done_data, o_busy, exp_words[N_EXP-1]);
        end
    endtask

    task automatic test_freeze();
        run_phase(1'b1, 1'b0);
        checks++;
        if ({halt_en, halt_start} !== 2'b01) begin
            fails++;
            $display("FAIL freeze_halt: enable/start %b expected 01", {halt_en, halt_start});
        end
        serve(20, 1'b1, 1'b0, 1'b1, 0);
        checks++;
        if (timed_out || n_starts != N_EXP || n_dones != 1 || unstable != 0) begin
            fails++;
            $display("FAIL freeze_counts: timeout %0d starts %0d dones %0d unstable %0d expected 0 %0d 1 0", timed_out, n_starts, n_dones, unstable, N_EXP);
        end
        for (int k = 0; k < N_EXP; k++) begin
            checks++;
            if (got[k] !== exp_words[k]) begin
                fails++;
                $display("FAIL freeze_word%0d: got %h expected %h", k, got[k], exp_words[k]);
            end
        end
    endtask

    task automatic test_rerun();
        run_phase(1'b0, 1'b1);
        checks++;
        if (en_cycles != 10 || halt_start !== 1'b1) begin
            fails++;
            $display("FAIL rerun_run: enable cycles %0d start %b expected 10 1", en_cycles, halt_start);
        end
        serve(20, 1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (timed_out || n_starts != N_EXP || n_dones != 1) begin
            fails++;
            $display("FAIL rerun_counts: timeout %0d starts %0d dones %0d expected 0 %0d 1", timed_out, n_starts, n_dones, N_EXP);
        end
        run_phase(1'b0, 1'b0);
        serve(5, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (timed_out || n_starts != N_EXP || n_dones != 1 || got[0] !== 8'hA5 || got[3] !== 8'hBE) begin
            fails++;
            $display("FAIL second_run: starts %0d dones %0d w0 %h w3 %h expected %0d 1 a5 be", n_starts, n_dones, got[0], got[3], N_EXP);
        end
    endtask

    task automatic test_halt_with_run();
        i_cc     = 11'h2A5;
        i_acc    = 16'hBEEF;
        @(negedge clk);
        i_run    = 1'b1;
        i_opcode = 5'd0;
        @(negedge clk);
        i_run = 1'b0;
        checks++;
        if ({o_cpu_enable, o_tx_start} !== 2'b10) begin
            fails++;
            $display("FAIL run_halt_same_cycle: enable/start %b expected 10", {o_cpu_enable, o_tx_start});
        end
        @(negedge clk);
        serve(3, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (timed_out || n_starts != N_EXP || got[1] !== 8'h02) begin
            fails++;
            $display("FAIL run_halt_words: starts %0d w1 %h expected %0d 02", n_starts, got[1], N_EXP);
        end
    endtask

    task automatic test_reset_mid();
        run_phase(1'b0, 1'b0);
        serve(20, 1'b0, 1'b0, 1'b0, 3);
        checks++;
        if (rst_outs !== 12'h000) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %h expected 000", rst_outs);
        end
        checks++;
        if (timed_out || n_starts != 3 || n_dones != 0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_abort: starts %0d dones %0d busy %b expected 3 0 0", n_starts, n_dones, o_busy);
        end
        run_phase(1'b0, 1'b0);
        serve(4, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (timed_out || n_starts != N_EXP || n_dones != 1 || got[0] !== 8'hA5 || got[2] !== 8'hEF) begin
            fails++;
            $display("FAIL mid_reset_rerun: starts %0d dones %0d w0 %h w2 %h expected %0d 1 a5 ef", n_starts, n_dones, got[0], got[2], N_EXP);
        end
    endtask

    task automatic test_back_pressure();
        run_phase(1'b0, 1'b0);
        serve(1000, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (timed_out || n_starts != N_EXP || n_dones != 1 || unstable != 0) begin
            fails++;
            $display("FAIL back_pressure: timeout %0d starts %0d dones %0d unstable %0d expected 0 %0d 1 0", timed_out, n_starts, n_dones, unstable, N_EXP);
        end
        checks++;
        if (got[N_EXP-1] !== exp_words[N_EXP-1]) begin
            fails++;
            $display("FAIL back_pressure_last: got %h expected %h", got[N_EXP-1], exp_words[N_EXP-1]);
        end
    endtask

    task automatic test_widths();
        logic [7:0] w8 [8];
        int starts8 = 0;
        int dones8  = 0;
        int wcnt    = 0;
        cc8  = 8'h5A;
        acc8 = 16'h1234;
        @(negedge clk);
        run8    = 1'b1;
        opcode8 = 5'd3;
        @(negedge clk);
        run8    = 1'b0;
        opcode8 = 5'd0;
        for (int c = 0; c < 200 && dones8 == 0; c++) begin
            @(negedge clk);
            tx_done8 = 1'b0;
            if (tx_start8) begin
                if (starts8 < 8) w8[starts8] = data_tx8;
                starts8++;
                wcnt = 3;
            end else if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) tx_done8 = 1'b1;
            end
            if (done8) dones8++;
        end
        repeat (4) @(negedge clk);
        if (tx_start8) starts8++;
        checks++;
        if (starts8 != N_EXP8 || dones8 != 1) begin
            fails++;
            $display("FAIL width8_counts: starts %0d dones %0d expected %0d 1", starts8, dones8, N_EXP8);
        end
        for (int k = 0; k < N_EXP8; k++) begin
            checks++;
            if (w8[k] !== exp_words8[k]) begin
                fails++;
                $display("FAIL width8_word%0d: got %h expected %h", k, w8[k], exp_words8[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_freeze();
        test_rerun();
        test_halt_with_run();
        test_reset_mid();
        test_back_pressure();
        test_widths();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bip_report_sequencer.md
Name: bip_report_sequencer

Overview:
- Run/report controller for the BIP-I core, placed between the UART link and the CPU datapath.
- On a host run command it enables the CPU and waits for the HALT opcode.
- It then snapshots the cycle counter and accumulator and streams them to the UART transmitter as a fixed sequence of words, one handshake per word.

Parameters:
- CANT_BITS_OPCODE, 5, opcode width.
- CC_LENGTH, 11, cycle counter width.
- ACC_LENGTH, 16, accumulator width.
- OUTPUT_WORD_LENGTH, 8, UART word width.
- HALT_OPCODE, 0, opcode value that ends a run.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  reset; single clock domain, synchronous, active-high.
- i_run  in  1  one-cycle host command to start a run.
- i_opcode  in  CANT_BITS_OPCODE  opcode currently executing.
- i_cc  in  CC_LENGTH  cycle counter value.
- i_acc  in  ACC_LENGTH  accumulator value.
- i_tx_done  in  1  UART tx finished current word (1-cycle pulse).
- o_cpu_enable  out  1  CPU clock enable.
- o_tx_start  out  1  1-cycle request to transmit o_data_tx.
- o_data_tx  out  OUTPUT_WORD_LENGTH  word to transmit.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  1-cycle pulse after the last word completes.

Behaviour:
- Derived constants:
  - CC_WORDS = ceil(CC_LENGTH/OUTPUT_WORD_LENGTH).
  - ACC_WORDS = ceil(ACC_LENGTH/OUTPUT_WORD_LENGTH).
  - N_WORDS = CC_WORDS + ACC_WORDS (+1 with checksum).
  - Defaults give 2 + 2 = 4 words.
- Reset:
  - State returns to IDLE.
  - All outputs go to 0, snapshot register to 0, word counter to 0.
- States: IDLE, RUN, SEND, WAIT_TX, DONE.
- IDLE:
  - o_cpu_enable = 0.
  - i_run = 1 -> RUN.
- RUN:
  - o_cpu_enable = 1.
  - When i_opcode == HALT_OPCODE is sampled, on the same edge:
    - capture i_cc and i_acc, each zero-extended to a whole number of words;
    - o_cpu_enable goes to 0;
    - clear the word counter;
    - move to SEND.
  - HALT seen at edge t gives enable low from t+1.
- SEND:
  - Exactly one cycle with o_tx_start = 1 and o_data_tx = word[counter]; then -> WAIT_TX.
- WAIT_TX:
  - o_tx_start = 0; o_data_tx is held stable.
  - On i_tx_done: if counter == N_WORDS-1 -> DONE, else increment the counter and go to SEND.
- DONE:
  - o_done = 1 for one cycle, then -> IDLE.
  - o_data_tx keeps the last word.
- Word order:
  - CC least-significant word first, then ACC least-significant word first.
  - Padding bits are 0.
- Boundary conditions:
  - i_run outside IDLE is ignored and does not restart anything.
  - i_tx_done outside WAIT_TX is ignored and not queued.
  - i_run and HALT in the same IDLE cycle: only the transition to RUN happens; HALT is evaluated from the next cycle.
  - The snapshot is frozen after capture; i_cc/i_acc changes during transmit have no effect.
  - i_reset at any state, including mid-transmit, aborts to IDLE; no further o_tx_start; o_done is not pulsed.
  - No timeout: WAIT_TX waits indefinitely for i_tx_done.

Optional Feature:
- Macro: BIP_REPORT_CHECKSUM_EN.
- Defined: one extra word is appended after the ACC words. It is the XOR of all preceding transmitted words, sent with the same SEND/WAIT_TX handshake, and N_WORDS includes it.
- Undefined: no checksum word; N_WORDS = CC_WORDS + ACC_WORDS.

Decomposition:
- Shared package (bip_pkg):
  - state enum;
  - localparam functions for CC_WORDS, ACC_WORDS, N_WORDS;
  - default HALT_OPCODE and OUTPUT_WORD_LENGTH constants.
- One sub-module, bip_word_serializer:
  - holds the zero-extended snapshot and word counter;
  - muxes out word[counter];
  - computes the running XOR.
- The FSM stays in the top.

Test Plan:
- Basic report: i_run pulse, i_opcode = 3 for 10 cycles, then 0 with i_cc = 11'h2A5, i_acc = 16'hBEEF; i_tx_done 20 cycles after each start.
  -> o_cpu_enable high for exactly the run, low 1 cycle after HALT.
  -> Words A5, 02, EF, BE; 4 o_tx_start pulses; o_done once.
- Checksum build, same stimulus -> fifth word F6, then o_done.
- Snapshot freeze: change i_cc/i_acc to all-ones during WAIT_TX -> transmitted words unchanged. Spurious i_tx_done in RUN and in SEND -> no effect.
- Ignore re-run: i_run pulses during RUN and during WAIT_TX -> no restart, word count still 4. After o_done, a new i_run starts a second run.
- Reset mid-operation: assert i_reset during WAIT_TX of word 2.
  -> Next cycle all outputs 0, state IDLE, no o_done.
  -> A following run sends the full 4-word sequence from word 0.
- Back-pressure and widths: i_tx_done delayed 1000 cycles -> o_data_tx stable, no extra o_tx_start. Parameterised run with CC_LENGTH = 8 -> 1 CC word, 3 words total.
